// File: rtl/cm_color_if.sv
// Quadrant colour write handshake between the CM configuration module and the colour bank.
interface cm_color_if #(
  parameter int c_addr_WIDTH = 2,
  parameter int c_data_WIDTH = 8
);
  logic [c_addr_WIDTH-1:0] c_addr;
  logic [c_data_WIDTH-1:0] c_data;
  logic                    c_valid;
  logic                    c_ready;

  modport master (output c_addr, output c_data, output c_valid, input c_ready);
  modport slave  (input c_addr, input c_data, input c_valid, output c_ready);
endinterface

// File: rtl/cm_color_bank.sv
// Four-quadrant colour bank driving the per-pixel colour toward the VGA stage.
// CM_COLOR_SHADOW_EN: when defined, writes land in shadow registers and commit on a VSync rising edge.
module cm_color_bank #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int POS_WIDTH    = 10,
  parameter int c_addr_WIDTH = 2,
  parameter int c_data_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  cm_color_if.slave               cfg,
  input  logic                    VSync,
  input  logic                    Vertical_Split,
  input  logic                    Horizontal_Split,
  input  logic [POS_WIDTH-1:0]    h_pos,
  input  logic [POS_WIDTH-1:0]    v_pos,
  input  logic                    pixel_en,
  output logic [c_data_WIDTH-1:0] pixel_data,
  output logic                    cfg_pending
);
  localparam int NQ = 2 ** c_addr_WIDTH;
  localparam logic [POS_WIDTH-1:0] H_HALF = POS_WIDTH'(H_ACTIVE / 2);
  localparam logic [POS_WIDTH-1:0] V_HALF = POS_WIDTH'(V_ACTIVE / 2);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t                  state_reg, state_next;
  logic                    ready_c;
  logic                    xfer;
  logic [NQ-1:0]           wr_en;
  logic [c_data_WIDTH-1:0] active_reg [NQ];
  logic [c_data_WIDTH-1:0] pixel_reg;
  logic [c_addr_WIDTH-1:0] sel;
  logic                    right, down;

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Ready is gated by reset so nothing can be accepted while the bank is held.
  always_comb begin
    state_next = state_reg;
    ready_c    = 1'b0;
    case (state_reg)
      IDLE: begin
        ready_c = rst_n;
        if (cfg.c_valid && rst_n) state_next = WRITE;
      end
      WRITE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign cfg.c_ready = ready_c;
  assign xfer        = cfg.c_valid && ready_c;

  genvar gi;
  generate
    for (gi = 0; gi < NQ; gi++) begin : g_wr_en
      assign wr_en[gi] = xfer && (cfg.c_addr == c_addr_WIDTH'(gi));
    end
  endgenerate

`ifdef CM_COLOR_SHADOW_EN
  logic [c_data_WIDTH-1:0] shadow_reg  [NQ];
  logic [c_data_WIDTH-1:0] shadow_next [NQ];
  logic                    vs_q_reg;
  logic                    pending_reg;
  logic                    commit;

  assign commit = VSync && !vs_q_reg;

  // Commit copies shadow next-state so a same-cycle write is captured.
  generate
    for (gi = 0; gi < NQ; gi++) begin : g_shadow
      assign shadow_next[gi] = wr_en[gi] ? cfg.c_data : shadow_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NQ; i++) begin
        shadow_reg[i] <= '0;
        active_reg[i] <= '0;
      end
      vs_q_reg    <= 1'b0;
      pending_reg <= 1'b0;
    end else begin
      vs_q_reg <= VSync;
      for (int i = 0; i < NQ; i++) begin
        shadow_reg[i] <= shadow_next[i];
        if (commit) active_reg[i] <= shadow_next[i];
      end
      if (commit)    pending_reg <= 1'b0;
      else if (xfer) pending_reg <= 1'b1;
    end
  end

  assign cfg_pending = pending_reg;
`else
  logic unused_vsync;
  assign unused_vsync = VSync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NQ; i++) active_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NQ; i++) begin
        if (wr_en[i]) active_reg[i] <= cfg.c_data;
      end
    end
  end

  assign cfg_pending = 1'b0;
`endif

  assign right = h_pos >= H_HALF;
  assign down  = v_pos >= V_HALF;
  assign sel   = {Horizontal_Split && down, Vertical_Split && right};

  always_ff @(posedge clk) begin
    if (!rst_n)        pixel_reg <= '0;
    else if (pixel_en) pixel_reg <= active_reg[sel];
    else               pixel_reg <= '0;
  end

  assign pixel_data = pixel_reg;
endmodule

// File: tb/tb_cm_color_bank.sv
// Directed, table-driven bench for cm_color_bank; expectations follow the CM_COLOR_SHADOW_EN build choice.
module tb_cm_color_bank;
`ifdef CM_COLOR_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       VSync, Vertical_Split, Horizontal_Split, pixel_en;
  logic [9:0] h_pos, v_pos;
  logic [7:0] pixel_data;
  logic       cfg_pending;
  int         n_checks = 0;
  int         n_fail   = 0;

  cm_color_if #(.c_addr_WIDTH(2), .c_data_WIDTH(8)) cif ();

  cm_color_bank dut (
    .clk(clk), .rst_n(rst_n), .cfg(cif), .VSync(VSync),
    .Vertical_Split(Vertical_Split), .Horizontal_Split(Horizontal_Split),
    .h_pos(h_pos), .v_pos(v_pos), .pixel_en(pixel_en),
    .pixel_data(pixel_data), .cfg_pending(cfg_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       vsp, hsp, en;
    logic [9:0] h, v;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic set_pix(input logic vsp, input logic hsp, input logic [9:0] h,
                         input logic [9:0] v, input logic en);
    Vertical_Split = vsp; Horizontal_Split = hsp; h_pos = h; v_pos = v; pixel_en = en;
  endtask

  // One write transfer, checking the one-cycle ready recovery.
  task automatic write(input logic [1:0] a, input logic [7:0] d);
    int waited = 0;
    cif.c_addr = a; cif.c_data = d; cif.c_valid = 1'b1;
    while (!cif.c_ready && waited < 10) begin
      tick();
      waited++;
    end
    check("write_ready_before", {31'd0, cif.c_ready}, 32'd1);
    tick();
    check("write_ready_low", {31'd0, cif.c_ready}, 32'd0);
    cif.c_valid = 1'b0;
    tick();
    check("write_ready_back", {31'd0, cif.c_ready}, 32'd1);
  endtask

  task automatic vsync_pulse();
    VSync = 1'b1;
    tick();
    VSync = 1'b0;
    tick();
  endtask

  initial begin
    int accepted;
    int pattern_ok;
    vecs[0]  = '{1, 1, 1, 10'd320, 10'd240, 8'h50};
    vecs[1]  = '{1, 1, 1, 10'd319, 10'd239, 8'h5A};
    vecs[2]  = '{1, 1, 1, 10'd319, 10'd240, 8'h24};
    vecs[3]  = '{1, 1, 1, 10'd320, 10'd239, 8'h5F};
    vecs[4]  = '{0, 0, 1, 10'd600, 10'd400, 8'h5A};
    vecs[5]  = '{1, 0, 1, 10'd320, 10'd400, 8'h5F};
    vecs[6]  = '{1, 0, 1, 10'd319, 10'd400, 8'h5A};
    vecs[7]  = '{0, 1, 1, 10'd600, 10'd240, 8'h24};
    vecs[8]  = '{0, 1, 1, 10'd600, 10'd239, 8'h5A};
    vecs[9]  = '{1, 1, 0, 10'd320, 10'd240, 8'h00};
    vecs[10] = '{1, 1, 1, 10'd639, 10'd479, 8'h50};

    rst_n = 1'b0; VSync = 1'b0;
    cif.c_valid = 1'b0; cif.c_addr = '0; cif.c_data = '0;
    set_pix(1, 1, 10'd400, 10'd300, 1);
    repeat (3) tick();
    check("rst_ready", {31'd0, cif.c_ready}, 32'd0);
    check("rst_pixel", {24'd0, pixel_data}, 32'd0);
    check("rst_pending", {31'd0, cfg_pending}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", {31'd0, cif.c_ready}, 32'd1);
    check("post_rst_pixel", {24'd0, pixel_data}, 32'd0);

    // LU and RU through a commit, split left/right
    write(2'b00, 8'h5A);
    write(2'b01, 8'h5F);
    check("pending_after_writes", {31'd0, cfg_pending}, {31'd0, SHADOW});
    vsync_pulse();
    set_pix(1, 0, 10'd100, 10'd0, 1); tick();
    check("vsplit_left", {24'd0, pixel_data}, 32'h5A);
    set_pix(1, 0, 10'd400, 10'd0, 1); tick();
    check("vsplit_right", {24'd0, pixel_data}, 32'h5F);

    // RD held in shadow until the frame boundary
    write(2'b11, 8'h50);
    check("pending_rd", {31'd0, cfg_pending}, {31'd0, SHADOW});
    set_pix(1, 1, 10'd400, 10'd300, 1); tick();
    check("rd_before_commit", {24'd0, pixel_data}, SHADOW ? 32'h00 : 32'h50);
    vsync_pulse();
    check("rd_after_commit", {24'd0, pixel_data}, 32'h50);
    check("pending_cleared", {31'd0, cfg_pending}, 32'd0);

    // write LD on the same cycle as the VSync rising edge
    set_pix(1, 1, 10'd100, 10'd300, 1);
    cif.c_addr = 2'b10; cif.c_data = 8'h12; cif.c_valid = 1'b1; VSync = 1'b1;
    check("same_cycle_ready", {31'd0, cif.c_ready}, 32'd1);
    tick();
    cif.c_valid = 1'b0;
    check("same_cycle_ready_low", {31'd0, cif.c_ready}, 32'd0);
    tick();
    check("same_cycle_pixel", {24'd0, pixel_data}, 32'h12);
    check("same_cycle_pending", {31'd0, cfg_pending}, 32'd0);
    VSync = 1'b0;
    tick();

    // continuous valid: only every second cycle is accepted
    accepted = 0; pattern_ok = 1;
    cif.c_addr = 2'b10; cif.c_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cif.c_data = 8'h20 + 8'(k);
      if (cif.c_ready) accepted++;
      if (cif.c_ready !== ((k % 2) == 0)) pattern_ok = 0;
      tick();
    end
    cif.c_valid = 1'b0;
    check("stream_accepted", accepted, 32'd3);
    check("stream_alternate", pattern_ok, 32'd1);
    tick();
    vsync_pulse();
    check("stream_last_word", {24'd0, pixel_data}, 32'h24);

    for (int i = 0; i < 11; i++) begin
      set_pix(vecs[i].vsp, vecs[i].hsp, vecs[i].h, vecs[i].v, vecs[i].en);
      tick();
      check($sformatf("vec%0d(%0d,%0d)", i, vecs[i].h, vecs[i].v),
            {24'd0, pixel_data}, {24'd0, vecs[i].exp});
    end

    // VSync held high commits once only
    write(2'b00, 8'h77);
    VSync = 1'b1;
    tick();
    write(2'b01, 8'h88);
    set_pix(1, 0, 10'd400, 10'd0, 1); tick();
    check("vs_held_ru", {24'd0, pixel_data}, SHADOW ? 32'h5F : 32'h88);
    set_pix(1, 0, 10'd100, 10'd0, 1); tick();
    check("vs_held_lu", {24'd0, pixel_data}, 32'h77);
    check("vs_held_pending", {31'd0, cfg_pending}, {31'd0, SHADOW});
    VSync = 1'b0;
    tick();

    // reset mid-write
    set_pix(1, 1, 10'd400, 10'd300, 1);
    cif.c_addr = 2'b11; cif.c_data = 8'h99; cif.c_valid = 1'b1;
    tick();
    cif.c_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    check("midrst_ready", {31'd0, cif.c_ready}, 32'd0);
    check("midrst_pixel", {24'd0, pixel_data}, 32'd0);
    check("midrst_pending", {31'd0, cfg_pending}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst_release_ready", {31'd0, cif.c_ready}, 32'd1);
    check("midrst_release_pixel", {24'd0, pixel_data}, 32'd0);
    vsync_pulse();
    check("midrst_commit_zero", {24'd0, pixel_data}, 32'd0);
    set_pix(1, 0, 10'd100, 10'd0, 1); tick();
    check("midrst_lu_zero", {24'd0, pixel_data}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
